// File: rtl/mips_pkg.sv
// Shared MIPS branch definitions: opcodes, 2-bit counter states and decode helpers
// used by the branch predictor and its history table.
package mips_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic logic is_cond_branch(input logic [5:0] op, input logic [4:0] rt);
        case (op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: return 1'b1;
            OP_REGIMM:                        return (rt == RT_BLTZ) || (rt == RT_BGEZ);
            default:                          return 1'b0;
        endcase
    endfunction

    // Word offset is sign-extended and scaled; overflow past 2^32 wraps silently.
    function automatic logic [31:0] branch_target(input logic [31:0] pcp4, input logic [15:0] imm);
        return pcp4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_predict_unit_bht.sv
// Branch history table: array of 2-bit saturating counters with one combinational
// read port (prediction bit) and one synchronous saturating-update write port.
module branch_predict_unit_bht
    import mips_pkg::*;
#(
    parameter int         DEPTH    = 64,
    parameter logic [1:0] CTR_INIT = 2'b01,
    localparam int        IDX_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_pred,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    ctr_t r_bht [DEPTH];
    ctr_t w_wr_cur;
    ctr_t w_wr_next;

    // Counter state register: reset wins over any concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bht[i] <= ctr_t'(CTR_INIT);
            end
        end else if (wr_en) begin
            r_bht[wr_idx] <= w_wr_next;
        end
    end

    // Next state of the written entry: step towards the outcome, saturating at the ends.
    always_comb begin
        w_wr_cur  = r_bht[wr_idx];
        w_wr_next = w_wr_cur;
        case (w_wr_cur)
            SNT:     w_wr_next = wr_taken ? WNT : SNT;
            WNT:     w_wr_next = wr_taken ? WT  : SNT;
            WT:      w_wr_next = wr_taken ? ST  : WNT;
            ST:      w_wr_next = wr_taken ? ST  : WT;
            default: w_wr_next = ctr_t'(CTR_INIT);
        endcase
    end

    // Read port returns the pre-update value; no bypass from the write port.
    always_comb begin
        rd_pred = r_bht[rd_idx][1];
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Pipelined MIPS branch unit: predicts conditional branches in ID from the BHT and
// resolves them in EX, raising a redirect on mispredict and keeping statistics.
module branch_predict_unit
    import mips_pkg::*;
#(
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CTR_INIT  = 2'b01,
    parameter int         STAT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [5:0]        id_opCode,
    input  logic [4:0]        id_rt,
    input  logic [31:0]       id_PCp4,
    input  logic [15:0]       id_branchImm,
    output logic              pred_taken,
    output logic [31:0]       pred_addr,
    input  logic              ex_valid,
    input  logic [5:0]        ex_opCode,
    input  logic [4:0]        ex_rt,
    input  logic [31:0]       ex_PCp4,
    input  logic [15:0]       ex_branchImm,
    input  logic              ex_predTaken,
    input  logic              ALUz,
    input  logic              rsZero,
    input  logic              rsNeg,
    output logic              mispredict,
    output logic [31:0]       redirect_addr,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic              w_id_is_br;
    logic              w_id_ctr_pred;
    logic [31:0]       w_id_target;
    logic              w_ex_is_br;
    logic              w_ex_taken;
    logic [31:0]       w_ex_target;
    logic [STAT_W-1:0] r_branch_cnt;
    logic [STAT_W-1:0] r_mispred_cnt;

    branch_predict_unit_bht #(
        .DEPTH    (BHT_DEPTH),
        .CTR_INIT (CTR_INIT)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (id_PCp4[IDX_W+1:2]),
        .rd_pred  (w_id_ctr_pred),
        .wr_en    (w_ex_is_br),
        .wr_idx   (ex_PCp4[IDX_W+1:2]),
        .wr_taken (w_ex_taken)
    );

    // ID-stage prediction and next-PC selection.
    always_comb begin
        w_id_is_br  = id_valid & is_cond_branch(id_opCode, id_rt);
        w_id_target = branch_target(id_PCp4, id_branchImm);
        pred_taken  = w_id_is_br & w_id_ctr_pred;
        pred_addr   = pred_taken ? w_id_target : id_PCp4;
    end

    // EX-stage condition evaluation from the comparator flags.
    always_comb begin
        w_ex_is_br  = ex_valid & is_cond_branch(ex_opCode, ex_rt);
        w_ex_target = branch_target(ex_PCp4, ex_branchImm);
        case (ex_opCode)
            OP_BEQ:    w_ex_taken = ALUz;
            OP_BNE:    w_ex_taken = !ALUz;
            OP_BLEZ:   w_ex_taken = rsNeg | rsZero;
            OP_BGTZ:   w_ex_taken = !rsNeg & !rsZero;
            OP_REGIMM: w_ex_taken = (ex_rt == RT_BGEZ) ? !rsNeg : rsNeg;
            default:   w_ex_taken = 1'b0;
        endcase
    end

    // Resolution outputs; a pending reset suppresses the redirect.
    always_comb begin
        mispredict    = !reset & w_ex_is_br & (w_ex_taken ^ ex_predTaken);
        redirect_addr = (w_ex_is_br & w_ex_taken) ? w_ex_target : ex_PCp4;
    end

    // Statistic counters wrap naturally at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt  <= {STAT_W{1'b0}};
            r_mispred_cnt <= {STAT_W{1'b0}};
        end else if (w_ex_is_br) begin
            r_branch_cnt <= r_branch_cnt + {{(STAT_W-1){1'b0}}, 1'b1};
            if (mispredict) begin
                r_mispred_cnt <= r_mispred_cnt + {{(STAT_W-1){1'b0}}, 1'b1};
            end else begin
                r_mispred_cnt <= r_mispred_cnt;
            end
        end else begin
            r_branch_cnt  <= r_branch_cnt;
            r_mispred_cnt <= r_mispred_cnt;
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [5:0]  id_opCode;
    logic [4:0]  id_rt;
    logic [31:0] id_PCp4;
    logic [15:0] id_branchImm;
    logic        pred_taken;
    logic [31:0] pred_addr;
    logic        ex_valid;
    logic [5:0]  ex_opCode;
    logic [4:0]  ex_rt;
    logic [31:0] ex_PCp4;
    logic [15:0] ex_branchImm;
    logic        ex_predTaken;
    logic        ALUz;
    logic        rsZero;
    logic        rsNeg;
    logic        mispredict;
    logic [31:0] redirect_addr;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0]  exp_tbl [3];
    logic [5:0]  v_op;
    logic [4:0]  v_rt;
    logic [31:0] v_pc;
    logic        v_tk;

    branch_predict_unit dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_opCode     (id_opCode),
        .id_rt         (id_rt),
        .id_PCp4       (id_PCp4),
        .id_branchImm  (id_branchImm),
        .pred_taken    (pred_taken),
        .pred_addr     (pred_addr),
        .ex_valid      (ex_valid),
        .ex_opCode     (ex_opCode),
        .ex_rt         (ex_rt),
        .ex_PCp4       (ex_PCp4),
        .ex_branchImm  (ex_branchImm),
        .ex_predTaken  (ex_predTaken),
        .ALUz          (ALUz),
        .rsZero        (rsZero),
        .rsNeg         (rsNeg),
        .mispredict    (mispredict),
        .redirect_addr (redirect_addr),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic [5:0] op, input logic [4:0] rt,
                            input logic [31:0] pc, input logic [15:0] imm);
        id_valid     = 1'b1;
        id_opCode    = op;
        id_rt        = rt;
        id_PCp4      = pc;
        id_branchImm = imm;
        #1;
    endtask

    task automatic drive_ex(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] pc,
                            input logic [15:0] imm, input logic pt, input logic az,
                            input logic rz, input logic rn);
        ex_valid     = 1'b1;
        ex_opCode    = op;
        ex_rt        = rt;
        ex_PCp4      = pc;
        ex_branchImm = imm;
        ex_predTaken = pt;
        ALUz         = az;
        rsZero       = rz;
        rsNeg        = rn;
        #1;
    endtask

    // Resolve one EX branch: check the combinational outputs, then clock it in.
    task automatic resolve(input string tag, input logic [5:0] op, input logic [4:0] rt,
                           input logic [31:0] pc, input logic [15:0] imm, input logic pt,
                           input logic az, input logic exp_mp, input logic [31:0] exp_rd);
        drive_ex(op, rt, pc, imm, pt, az, 1'b0, 1'b0);
        chk({tag, "_mp"}, {31'd0, mispredict}, {31'd0, exp_mp});
        chk({tag, "_rd"}, redirect_addr, exp_rd);
        step();
        ex_valid = 1'b0;
    endtask

    initial begin
        exp_tbl[0] = 6'b010110;
        exp_tbl[1] = 6'b100101;
        exp_tbl[2] = 6'b101010;
        reset = 1'b1;
        id_valid = 1'b0; id_opCode = 6'd0; id_rt = 5'd0; id_PCp4 = 32'h0; id_branchImm = 16'h0;
        ex_valid = 1'b0; ex_opCode = 6'd0; ex_rt = 5'd0; ex_PCp4 = 32'h200; ex_branchImm = 16'h0;
        ex_predTaken = 1'b0; ALUz = 1'b0; rsZero = 1'b0; rsNeg = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_bcnt", branch_cnt, 32'd0);
        chk("rst_mcnt", mispred_cnt, 32'd0);
        chk("rst_mp", {31'd0, mispredict}, 32'd0);
        chk("rst_rd", redirect_addr, 32'h200);
        chk("rst_pt", {31'd0, pred_taken}, 32'd0);

        // 1/2: first BEQ predicts not-taken, resolves taken
        drive_id(OP_BEQ, 5'd0, 32'h104, 16'h0003);
        chk("t1_pt", {31'd0, pred_taken}, 32'd0);
        chk("t1_pa", pred_addr, 32'h104);
        resolve("t2", OP_BEQ, 5'd0, 32'h104, 16'h0003, 1'b0, 1'b1, 1'b1, 32'h110);
        #1;
        chk("t2_pt", {31'd0, pred_taken}, 32'd1);
        chk("t2_pa", pred_addr, 32'h110);
        chk("t2_bcnt", branch_cnt, 32'd1);
        chk("t2_mcnt", mispred_cnt, 32'd1);
        drive_id(6'd0, 5'd0, 32'h104, 16'h0003);
        chk("t2_nonbr_pt", {31'd0, pred_taken}, 32'd0);
        chk("t2_nonbr_pa", pred_addr, 32'h104);

        // 3: saturate to ST, then one not-taken drops to WT
        resolve("t3a", OP_BEQ, 5'd0, 32'h208, 16'h0010, 1'b0, 1'b1, 1'b1, 32'h248);
        resolve("t3b", OP_BEQ, 5'd0, 32'h208, 16'h0010, 1'b1, 1'b1, 1'b0, 32'h248);
        resolve("t3c", OP_BEQ, 5'd0, 32'h208, 16'h0010, 1'b1, 1'b1, 1'b0, 32'h248);
        resolve("t3d", OP_BEQ, 5'd0, 32'h208, 16'h0010, 1'b1, 1'b1, 1'b0, 32'h248);
        drive_id(OP_BEQ, 5'd0, 32'h208, 16'h0010);
        chk("t3_st_pt", {31'd0, pred_taken}, 32'd1);
        resolve("t3e", OP_BEQ, 5'd0, 32'h208, 16'h0010, 1'b1, 1'b0, 1'b1, 32'h208);
        #1;
        chk("t3_wt_pt", {31'd0, pred_taken}, 32'd1);
        chk("t3_wt_pa", pred_addr, 32'h248);
        chk("t3_bcnt", branch_cnt, 32'd6);
        chk("t3_mcnt", mispred_cnt, 32'd3);

        // 4: every branch type against rs = -1 / 0 / +5, backward target PCp4-4
        for (int c = 0; c < 3; c++) begin
            for (int t = 0; t < 6; t++) begin
                case (t)
                    0:       begin v_op = OP_BEQ;    v_rt = 5'd0;    end
                    1:       begin v_op = OP_BNE;    v_rt = 5'd0;    end
                    2:       begin v_op = OP_BLEZ;   v_rt = 5'd0;    end
                    3:       begin v_op = OP_BGTZ;   v_rt = 5'd0;    end
                    4:       begin v_op = OP_REGIMM; v_rt = RT_BLTZ; end
                    default: begin v_op = OP_REGIMM; v_rt = RT_BGEZ; end
                endcase
                v_pc = 32'h400 + 32'((c * 6 + t + 8) * 4);
                v_tk = exp_tbl[c][t];
                drive_ex(v_op, v_rt, v_pc, 16'hFFFF, 1'b0, (c == 1), (c == 1), (c == 0));
                chk($sformatf("t4_c%0d_t%0d_mp", c, t), {31'd0, mispredict}, {31'd0, v_tk});
                chk($sformatf("t4_c%0d_t%0d_rd", c, t), redirect_addr, v_tk ? v_pc - 32'd4 : v_pc);
                step();
                ex_valid = 1'b0;
            end
        end
        resolve("t4_bne", OP_BNE, 5'd0, 32'h500, 16'hFFFF, 1'b1, 1'b1, 1'b1, 32'h500);
        drive_ex(6'd0, 5'd0, 32'h504, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_rtype_mp", {31'd0, mispredict}, 32'd0);
        chk("t4_rtype_rd", redirect_addr, 32'h504);
        drive_ex(OP_REGIMM, 5'd2, 32'h508, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_regimm2_mp", {31'd0, mispredict}, 32'd0);
        step();
        ex_valid = 1'b0;
        #1;
        chk("t4_bcnt", branch_cnt, 32'd25);
        chk("t4_mcnt", mispred_cnt, 32'd13);

        // 5: ID and EX hit the same index in one cycle; ID must see the old counter
        drive_id(OP_BEQ, 5'd0, 32'h0F0, 16'h0001);
        drive_ex(OP_BEQ, 5'd0, 32'h0F0, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_same_pt", {31'd0, pred_taken}, 32'd0);
        chk("t5_same_mp", {31'd0, mispredict}, 32'd1);
        step();
        ex_valid = 1'b0;
        #1;
        chk("t5_after_pt", {31'd0, pred_taken}, 32'd1);
        chk("t5_after_pa", pred_addr, 32'h0F4);
        drive_ex(OP_BEQ, 5'd0, 32'h0E0, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        ex_valid = 1'b0;
        #1;
        chk("t5_inv_mp", {31'd0, mispredict}, 32'd0);
        chk("t5_inv_rd", redirect_addr, 32'h0E0);
        step();
        step();
        drive_id(OP_BEQ, 5'd0, 32'h0E0, 16'h0001);
        chk("t5_inv_pt", {31'd0, pred_taken}, 32'd0);
        chk("t5_bcnt", branch_cnt, 32'd26);
        chk("t5_mcnt", mispred_cnt, 32'd14);

        // 6: reset mid-stream with a concurrent taken resolve at 0x0E0
        reset = 1'b1;
        drive_ex(OP_BEQ, 5'd0, 32'h0E0, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_rst_mp", {31'd0, mispredict}, 32'd0);
        step();
        reset    = 1'b0;
        ex_valid = 1'b0;
        #1;
        chk("t6_bcnt", branch_cnt, 32'd0);
        chk("t6_mcnt", mispred_cnt, 32'd0);
        chk("t6_pt_0e0", {31'd0, pred_taken}, 32'd0);
        drive_id(OP_BEQ, 5'd0, 32'h104, 16'h0003);
        chk("t6_pt_104", {31'd0, pred_taken}, 32'd0);
        drive_id(OP_BEQ, 5'd0, 32'h208, 16'h0010);
        chk("t6_pt_208", {31'd0, pred_taken}, 32'd0);
        drive_id(OP_BEQ, 5'd0, 32'h0F0, 16'h0001);
        chk("t6_pt_0f0", {31'd0, pred_taken}, 32'd0);
        resolve("t6_post", OP_BEQ, 5'd0, 32'h0E0, 16'h0001, 1'b0, 1'b1, 1'b1, 32'h0E4);
        drive_id(OP_BEQ, 5'd0, 32'h0E0, 16'h0001);
        chk("t6_post_pt", {31'd0, pred_taken}, 32'd1);
        chk("t6_post_bcnt", branch_cnt, 32'd1);
        chk("t6_post_mcnt", mispred_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
